bpsk_mod: RTL and testbench
===========================

# bpsk_mod

Baseband-to-carrier BPSK modulator that sits directly downstream of the m-sequence generator. On each symbol boundary it samples one data bit from `data_sig`. It can optionally differentially encode that bit. It then emits a signed sinusoidal carrier whose phase is 0° or 180° according to the encoded bit, for CPS full carrier periods per symbol. The output sample stream feeds the channel/DAC stage.

## Interface
- `CPS`, 4: carrier periods per symbol, range 1..255.
- `DIFF`, 1: 1 = differential encoding (`enc = enc_prev XOR data`); 0 = direct (`enc = data`).
- `clk_sig`  in  1  system clock; all logic on rising edge.
- `rst_sig`  in  1  asynchronous, active-low reset.
- `en_sig`  in  1  sample-rate enable; the block advances one sample per cycle with `en_sig`=1.
- `data_sig`  in  1  serial data bit (m-sequence output); sampled only on symbol-boundary enable cycles.
- `bpsk_sig`  out  8  signed two's-complement carrier sample.
- `valid_sig`  out  1  high when `bpsk_sig` holds a sample produced by an enabled cycle.
- `bit_strobe`  out  1  one-cycle pulse, coincident with the first sample of each symbol.
- `sym_sig`  out  1  encoded bit of the symbol currently on `bpsk_sig`.

## Operation
- Sine LUT has 16 entries, index k = 0..15: 0, 49, 90, 117, 127, 117, 90, 49, 0, −49, −90, −117, −127, −117, −90, −49.
- Counters:
  - Phase index k is 4 bits, wraps 15→0.
  - Carrier counter c is 8 bits, counts 0..CPS−1 and increments when k wraps; it wraps CPS−1→0.
  - Both counters advance only on `en_sig`=1 cycles.
- A symbol boundary is an enabled cycle with k=0 and c=0. On that cycle:
  - `data_sig` is captured.
  - `enc` is computed per DIFF. The `enc_prev` register updates to `enc`.
  - `enc` applies to that same cycle's sample.
- Sample mapping: enc=0 → +LUT[k]; enc=1 → −LUT[k]. Negating −127 gives +127, so no overflow is possible. Output range is [−127, 127].
- FSM has two states:
  - IDLE: entered on reset. Outputs are held at reset values. It moves to RUN on the first `en_sig`=1 cycle; that cycle is a symbol boundary (k=0, c=0).
  - RUN: stays in RUN until reset. When `en_sig`=0, counters, `enc_prev`, `bpsk_sig` and `sym_sig` hold. `valid_sig` and `bit_strobe` drive 0.
- Symbol length is exactly 16·CPS enabled cycles, independent of gaps in `en_sig`.
- `data_sig` is ignored on non-boundary cycles, even if it toggles.

## Timing
- All outputs are registered. Latency is 1 cycle: an enabled cycle at edge t produces its sample on `bpsk_sig`/`valid_sig` after edge t+1.
- `bit_strobe` rises with the k=0 sample of a symbol and lasts one cycle. `sym_sig` changes in that same cycle.
- Reset values (asynchronous, while `rst_sig`=0):
  - Outputs: `bpsk_sig`=0, `valid_sig`=0, `bit_strobe`=0, `sym_sig`=0.
  - Internal state: k=0, c=0, `enc_prev`=0, FSM in IDLE.
- Reset mid-symbol: the partial symbol is abandoned and outputs clear immediately (not on a clock edge). After release, the next enabled cycle is a fresh boundary with the differential reference restored to 0.
- Reset release with `en_sig`=1 already high: the first rising edge with `rst_sig`=1 is the first boundary.
- `en_sig` dropping on a boundary cycle: the boundary is not consumed. The next enabled cycle is still the boundary and samples `data_sig` then.
- Carrier counter wrap: c returns to 0 only when k wraps at c=CPS−1. With CPS=1, every k wrap is a boundary.

## Test plan
- Reset check: hold `rst_sig`=0 with `en_sig`=1 and `data_sig` toggling. All outputs must stay 0 and no `bit_strobe` may appear. Assert reset mid-symbol after 23 enabled cycles: outputs clear asynchronously, and the first post-release sample is 0 with `bit_strobe`=1.
- DIFF=0, CPS=1, `data_sig`=0 constant, `en_sig`=1: `bpsk_sig` must be 0, 49, 90, 117, 127, … −49 repeating, with `bit_strobe` every 16 cycles. With `data_sig`=1 constant, the sequence must be 0, −49, −90, …, 49.
- DIFF=1, CPS=2, data bits 1,1,0,1: `sym_sig` must be 1,0,0,1. The sample 4 cycles after each `bit_strobe` must be −127, 127, 127, −127. Each symbol must span 32 valid samples.
- Enable gaps: `en_sig` = 1 for 3 cycles, then 0 for 5 cycles, repeating. Samples must be identical in value and order to the gapless run. `valid_sig` must count exactly 16·CPS per `bit_strobe`. `data_sig` toggling inside gaps must not alter `sym_sig`.
- Boundary stall: deassert `en_sig` on the k=0, c=0 cycle and change `data_sig` during the stall. The captured bit must be the value present on the next enabled cycle.
- Chain with the m-sequence generator (M=16, same clock/reset, DIFF=0, CPS=1, `en_sig`=1): `sym_sig` at each `bit_strobe` must equal `data_sig` on the corresponding boundary cycle over 100 symbols. `bpsk_sig` must never exceed |127|.

Source files
------------

// File: rtl/bpsk_mod.sv
// BPSK modulator: samples one data bit per symbol, optionally differentially
// encodes it, and emits CPS periods of a 16-point signed sine carrier per symbol.
module bpsk_mod #(
  parameter int unsigned CPS  = 4,
  parameter bit          DIFF = 1'b1
) (
  input  logic              clk_sig,
  input  logic              rst_sig,
  input  logic              en_sig,
  input  logic              data_sig,
  output logic signed [7:0] bpsk_sig,
  output logic              valid_sig,
  output logic              bit_strobe,
  output logic              sym_sig
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] C_LAST = 8'(CPS - 1);

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [7:0]        c_q, c_d;
  logic              enc_prev_q, enc_prev_d;
  logic signed [7:0] bpsk_q, bpsk_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              sym_q, sym_d;

  logic              boundary;
  logic              enc_cur;
  logic signed [7:0] lut_val;

  function automatic logic signed [7:0] sine_lut(input logic [3:0] idx);
    logic signed [7:0] v;
    case (idx)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd49;
      4'd2:    v = 8'sd90;
      4'd3:    v = 8'sd117;
      4'd4:    v = 8'sd127;
      4'd5:    v = 8'sd117;
      4'd6:    v = 8'sd90;
      4'd7:    v = 8'sd49;
      4'd8:    v = 8'sd0;
      4'd9:    v = -8'sd49;
      4'd10:   v = -8'sd90;
      4'd11:   v = -8'sd117;
      4'd12:   v = -8'sd127;
      4'd13:   v = -8'sd117;
      4'd14:   v = -8'sd90;
      default: v = -8'sd49;
    endcase
    return v;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    enc_prev_d = enc_prev_q;
    bpsk_d     = bpsk_q;
    sym_d      = sym_q;
    valid_d    = 1'b0;
    strobe_d   = 1'b0;

    boundary = (k_q == 4'd0) && (c_q == 8'd0);
    lut_val  = sine_lut(k_q);

    // The encoded bit of a new symbol applies to the boundary sample itself.
    enc_cur = enc_prev_q;
    if (boundary) begin
      enc_cur = DIFF ? (enc_prev_q ^ data_sig) : data_sig;
    end

    case (state_q)
      IDLE:    if (en_sig) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (en_sig) begin
      k_d = k_q + 4'd1;
      if (k_q == 4'd15) begin
        c_d = (c_q == C_LAST) ? 8'd0 : c_q + 8'd1;
      end
      enc_prev_d = enc_cur;
      bpsk_d     = enc_cur ? -lut_val : lut_val;
      sym_d      = enc_cur;
      valid_d    = 1'b1;
      strobe_d   = boundary;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      state_q    <= IDLE;
      k_q        <= 4'd0;
      c_q        <= 8'd0;
      enc_prev_q <= 1'b0;
      bpsk_q     <= 8'sd0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      sym_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      enc_prev_q <= enc_prev_d;
      bpsk_q     <= bpsk_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      sym_q      <= sym_d;
    end
  end

  assign bpsk_sig   = bpsk_q;
  assign valid_sig  = valid_q;
  assign bit_strobe = strobe_q;
  assign sym_sig    = sym_q;

endmodule

// File: tb/tb_bpsk_mod.sv
// Self-checking bench for bpsk_mod: three parameterisations driven in parallel,
// compared every cycle against a sample-count model plus directed vectors.
module tb_bpsk_mod;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic data;

  logic signed [7:0] bpsk   [3];
  logic              valid  [3];
  logic              strobe [3];
  logic              sym    [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bpsk_mod #(.CPS(1), .DIFF(1'b0)) u_d0 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(en), .data_sig(data),
    .bpsk_sig(bpsk[0]), .valid_sig(valid[0]), .bit_strobe(strobe[0]), .sym_sig(sym[0]));
  bpsk_mod #(.CPS(2), .DIFF(1'b1)) u_d1 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(en), .data_sig(data),
    .bpsk_sig(bpsk[1]), .valid_sig(valid[1]), .bit_strobe(strobe[1]), .sym_sig(sym[1]));
  bpsk_mod #(.CPS(4), .DIFF(1'b1)) u_d2 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(en), .data_sig(data),
    .bpsk_sig(bpsk[2]), .valid_sig(valid[2]), .bit_strobe(strobe[2]), .sym_sig(sym[2]));

  int sine_tab [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};

  function automatic int cps_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic bit diff_of(input int i);
    return (i != 0);
  endfunction

  // Reference model: position within the stream is just the count of enabled samples.
  int                n_en    [3];
  bit                m_enc   [3];
  logic signed [7:0] m_bpsk  [3];
  bit                m_valid [3];
  bit                m_strobe[3];
  bit                m_sym   [3];

  always @(posedge clk or negedge rst_n) begin
    int per;
    int s;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        n_en[i] = 0; m_enc[i] = 1'b0; m_bpsk[i] = 8'sd0;
        m_valid[i] = 1'b0; m_strobe[i] = 1'b0; m_sym[i] = 1'b0;
      end else if (en) begin
        per = 16 * cps_of(i);
        if (n_en[i] % per == 0) m_enc[i] = diff_of(i) ? (m_enc[i] ^ data) : data;
        s = sine_tab[n_en[i] % 16];
        m_bpsk[i]   = 8'(m_enc[i] ? -s : s);
        m_strobe[i] = (n_en[i] % per == 0);
        m_valid[i]  = 1'b1;
        m_sym[i]    = m_enc[i];
        n_en[i]++;
      end else begin
        m_valid[i]  = 1'b0;
        m_strobe[i] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_dut%0d {bpsk,valid,strobe,sym}", i),
            {21'd0, bpsk[i], valid[i], strobe[i], sym[i]},
            {21'd0, m_bpsk[i], m_valid[i], m_strobe[i], m_sym[i]});
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic tick(input bit e, input bit d);
    en = e;
    data = d;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    data = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit                en;
    bit                data;
    logic signed [7:0] exp_bpsk;
    bit                exp_strobe;
  } vec_t;

  vec_t tbl [32];

  bit                dseq [$];
  logic signed [7:0] ref0 [$], ref2 [$], got0 [$], got2 [$];
  bit                bq   [$];

  initial begin
    bit   sym_bits [4];
    logic signed [7:0] at4 [4];
    int   vcnt [3];
    bit   seen [3];
    int   n;
    int   nstrobe;
    logic [15:0] lfsr;
    bit   d;

    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{en: 1'b1, data: 1'b0, exp_bpsk: 8'(sine_tab[i]),  exp_strobe: (i == 0)};
      tbl[16 + i] = '{en: 1'b1, data: 1'b1, exp_bpsk: 8'(-sine_tab[i]), exp_strobe: (i == 0)};
    end

    // Reset held with enable high and data toggling: nothing may come out.
    rst_n = 1'b0; en = 1'b1; data = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, i[0]);
      check("reset_hold_strobe", {31'd0, strobe[2]}, 32'd0);
      check("reset_hold_bpsk", {24'd0, bpsk[2]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) tick(1'b1, 1'($urandom_range(0, 1)));
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_clear_dut%0d", i),
            {21'd0, bpsk[i], valid[i], strobe[i], sym[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    check("post_reset_first_bpsk", {{24{bpsk[2][7]}}, bpsk[2]}, 32'd0);
    check("post_reset_first_strobe", {31'd0, strobe[2]}, 32'd1);

    // Direct-mode carrier table, data 0 then data 1.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick(tbl[i].en, tbl[i].data);
      check($sformatf("tbl[%0d].bpsk", i), {{24{bpsk[0][7]}}, bpsk[0]},
            {{24{tbl[i].exp_bpsk[7]}}, tbl[i].exp_bpsk});
      check($sformatf("tbl[%0d].strobe", i), {31'd0, strobe[0]}, {31'd0, tbl[i].exp_strobe});
    end

    // Differential CPS=2: bits 1,1,0,1 encode to 1,0,0,1.
    do_reset();
    sym_bits = '{1'b1, 1'b0, 1'b0, 1'b1};
    at4      = '{-8'sd127, 8'sd127, 8'sd127, -8'sd127};
    vcnt[1] = 0;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 32; j++) begin
        tick(1'b1, (s == 2) ? 1'b0 : 1'b1);
        if (valid[1]) vcnt[1]++;
        if (j == 0) begin
          check($sformatf("diff_sym%0d_strobe", s), {31'd0, strobe[1]}, 32'd1);
          check($sformatf("diff_sym%0d_sym", s), {31'd0, sym[1]}, {31'd0, sym_bits[s]});
        end
        if (j == 4) begin
          check($sformatf("diff_sym%0d_k4", s), {{24{bpsk[1][7]}}, bpsk[1]},
                {{24{at4[s][7]}}, at4[s]});
        end
      end
    end
    check("diff_valid_count", vcnt[1], 32'd128);

    // Gapless reference run, then the same enabled-cycle data with 3-on/5-off gaps.
    for (int i = 0; i < 128; i++) dseq.push_back(1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 128; i++) begin
      tick(1'b1, dseq[i]);
      ref0.push_back(bpsk[0]);
      ref2.push_back(bpsk[2]);
    end
    do_reset();
    n = 0;
    vcnt = '{0, 0, 0};
    seen = '{1'b0, 1'b0, 1'b0};
    while (n < 128) begin
      for (int j = 0; j < 8; j++) begin
        if (j < 3 && n < 128) begin
          tick(1'b1, dseq[n]);
          n++;
        end else begin
          tick(1'b0, 1'($urandom_range(0, 1)));
        end
        if (valid[0]) got0.push_back(bpsk[0]);
        if (valid[2]) got2.push_back(bpsk[2]);
        for (int i = 1; i < 3; i++) begin
          if (strobe[i]) begin
            if (seen[i]) check($sformatf("gap_valid_per_symbol_dut%0d", i), vcnt[i], 16 * cps_of(i));
            seen[i] = 1'b1;
            vcnt[i] = 0;
          end
          if (valid[i]) vcnt[i]++;
        end
      end
    end
    check("gap_len_dut0", got0.size(), 128);
    check("gap_len_dut2", got2.size(), 128);
    for (int i = 0; i < 128 && i < got0.size() && i < got2.size(); i++) begin
      check($sformatf("gap_order_dut0[%0d]", i), {24'd0, got0[i]}, {24'd0, ref0[i]});
      check($sformatf("gap_order_dut2[%0d]", i), {24'd0, got2[i]}, {24'd0, ref2[i]});
    end

    // Stall on the boundary: data changes during the stall, the enabled cycle's value wins.
    do_reset();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("stall_no_strobe", {31'd0, strobe[0]}, 32'd0);
    tick(1'b1, 1'b1);
    check("stall_strobe", {31'd0, strobe[0]}, 32'd1);
    check("stall_sym", {31'd0, sym[0]}, 32'd1);
    check("stall_bpsk0", {{24{bpsk[0][7]}}, bpsk[0]}, 32'd0);
    tick(1'b1, 1'b0);
    check("stall_bpsk1", {{24{bpsk[0][7]}}, bpsk[0]}, 32'($signed(-49)));
    check("stall_sym_hold", {31'd0, sym[0]}, 32'd1);

    // Random enable/data soak against the model.
    do_reset();
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    // Chained m-sequence source (16-bit Fibonacci LFSR), 100 symbols.
    do_reset();
    lfsr = 16'hACE1;
    nstrobe = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      d = lfsr[0];
      if (cyc % 16 == 0) bq.push_back(d);
      tick(1'b1, d);
      if (strobe[0]) begin
        nstrobe++;
        check("chain_sym", {31'd0, sym[0]}, {31'd0, (bq.size() > 0) ? bq.pop_front() : ~sym[0]});
      end
      check("chain_range", {31'd0, bpsk[0] == -8'sd128}, 32'd0);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    check("chain_strobe_count", nstrobe, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
